// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/execute boundary register feeding the ALU (A, B, op) behind a valid/ready handshake.
// Optional ALU_ISSUE_FWD_EN adds a writeback bypass port into the rs1/rs2 operand selection.
module alu_issue_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      out_rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_pc,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic            illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1, w_rs2, w_imm_i, w_imm_u, w_a, w_b;
    logic [3:0]      w_op;
    logic            w_rw, w_br, w_ill, w_accept, w_shift;

    logic            r_valid, r_rw, r_br, r_ill;
    logic [XLEN-1:0] r_a, r_b, r_pc;
    logic [3:0]      r_op;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_rd     = instr[11:7];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_shift  = (w_f3 == 3'b001) | (w_f3 == 3'b101);
    assign in_ready = (~r_valid | out_ready) & ~flush;
    assign w_accept = in_valid & in_ready;

`ifdef ALU_ISSUE_FWD_EN
    assign w_rs1 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[19:15]) ? wb_data : rs1_data;
    assign w_rs2 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[24:20]) ? wb_data : rs2_data;
`else
    assign w_rs1 = rs1_data;
    assign w_rs2 = rs2_data;
`endif

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_op  = 4'b0000;
        w_rw  = 1'b0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_a  = w_rs1;
                w_b  = w_shift ? (w_rs2 & 32'h1F) : w_rs2;
                w_op = {instr[30], w_f3};
                w_rw = |w_rd;
            end
            OPC_OP_IMM: begin
                w_a  = w_rs1;
                w_b  = (w_f3 == 3'b101) ? {27'b0, instr[24:20]} : w_imm_i;
                w_op = {(w_f3 == 3'b101) & instr[30], w_f3};
                w_rw = |w_rd;
            end
            OPC_LUI: begin
                w_b  = w_imm_u;
                w_rw = |w_rd;
            end
            OPC_AUIPC: begin
                w_a  = pc;
                w_b  = w_imm_u;
                w_rw = |w_rd;
            end
            OPC_BRANCH: begin
                w_a  = w_rs1;
                w_b  = w_rs2;
                w_br = 1'b1;
                w_op = (w_f3[2:1] == 2'b10) ? 4'b0010 : (w_f3[2:1] == 2'b11) ? 4'b0011 : 4'b1000;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Data registers only move on accept; a drain or flush just drops valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 4'b0000;
            r_rd    <= 5'd0;
            r_rw    <= 1'b0;
            r_br    <= 1'b0;
            r_f3    <= 3'b000;
            r_pc    <= RESET_PC;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_rd    <= w_rd;
            r_rw    <= w_rw;
            r_br    <= w_br;
            r_f3    <= w_f3;
            r_pc    <= pc;
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    assign out_rd     = r_rd;
    assign reg_write  = r_rw;
    assign is_branch  = r_br;
    assign out_funct3 = r_f3;
    assign out_pc     = r_pc;
    assign illegal    = r_ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven decode vectors plus hand-written stall, flush and reset sequences.
module tb_alu_issue_stage;
    typedef struct {
        logic [31:0] instr, pc, rs1, rs2, a, b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, br, ill;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
    logic        in_ready, out_valid, reg_write, is_branch, illegal;
    logic [31:0] alu_a, alu_b, out_pc;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
`ifdef ALU_ISSUE_FWD_EN
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
`endif
    int n_chk = 0, n_fail = 0;
    vec_t v[14];

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd), .reg_write(reg_write),
        .is_branch(is_branch), .out_funct3(out_funct3), .out_pc(out_pc),
`ifdef ALU_ISSUE_FWD_EN
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        in_valid = 1'b1;
        instr    = x.instr;
        pc       = x.pc;
        rs1_data = x.rs1;
        rs2_data = x.rs2;
    endtask

    task automatic chk_vec(input vec_t x, input int i);
        chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d a", i), alu_a, x.a);
        chk($sformatf("v%0d b", i), alu_b, x.b);
        chk($sformatf("v%0d op", i), 32'(alu_op), 32'(x.op));
        chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(x.rd));
        chk($sformatf("v%0d f3", i), 32'(out_funct3), 32'(x.f3));
        chk($sformatf("v%0d pc", i), out_pc, x.pc);
        chk($sformatf("v%0d rw", i), 32'(reg_write), 32'(x.rw));
        chk($sformatf("v%0d br", i), 32'(is_branch), 32'(x.br));
        chk($sformatf("v%0d ill", i), 32'(illegal), 32'(x.ill));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " a"}, alu_a, 32'd0);
        chk({tag, " b"}, alu_b, 32'd0);
        chk({tag, " op"}, 32'(alu_op), 32'd0);
        chk({tag, " rd"}, 32'(out_rd), 32'd0);
        chk({tag, " rw"}, 32'(reg_write), 32'd0);
        chk({tag, " br"}, 32'(is_branch), 32'd0);
        chk({tag, " ill"}, 32'(illegal), 32'd0);
        chk({tag, " f3"}, 32'(out_funct3), 32'd0);
        chk({tag, " pc"}, out_pc, 32'd0);
    endtask

    initial begin
        v[0]  = '{32'h002081B3, 32'h1000, 32'h5, 32'h7, 32'h5, 32'h7, 4'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0};
        v[1]  = '{32'h40435293, 32'h1004, 32'h80000000, 32'h0, 32'h80000000, 32'h4, 4'hD, 5'd5, 3'd5, 1'b1, 1'b0, 1'b0};
        v[2]  = '{32'h407352B3, 32'h1008, 32'hF0000000, 32'h24, 32'hF0000000, 32'h4, 4'hD, 5'd5, 3'd5, 1'b1, 1'b0, 1'b0};
        v[3]  = '{32'hFFF00013, 32'h100C, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 4'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        v[4]  = '{32'h123450B7, 32'h1010, 32'h77, 32'h88, 32'h0, 32'h12345000, 4'h0, 5'd1, 3'd5, 1'b1, 1'b0, 1'b0};
        v[5]  = '{32'h00001117, 32'h100, 32'h77, 32'h88, 32'h100, 32'h1000, 4'h0, 5'd2, 3'd1, 1'b1, 1'b0, 1'b0};
        v[6]  = '{32'h40208233, 32'h1014, 32'h9, 32'h3, 32'h9, 32'h3, 4'h8, 5'd4, 3'd0, 1'b1, 1'b0, 1'b0};
        v[7]  = '{32'h00208063, 32'h1018, 32'hB, 32'hC, 32'hB, 32'hC, 4'h8, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        v[8]  = '{32'h0020E063, 32'h101C, 32'hB, 32'hC, 32'hB, 32'hC, 4'h3, 5'd0, 3'd6, 1'b0, 1'b1, 1'b0};
        v[9]  = '{32'h0020C063, 32'h1020, 32'hB, 32'hC, 32'hB, 32'hC, 4'h2, 5'd0, 3'd4, 1'b0, 1'b1, 1'b0};
        v[10] = '{32'h0000000F, 32'h1024, 32'h5, 32'h6, 32'h0, 32'h0, 4'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        v[11] = '{32'h0F00F313, 32'h1028, 32'h12345678, 32'h0, 32'h12345678, 32'hF0, 4'h7, 5'd6, 3'd7, 1'b1, 1'b0, 1'b0};
        v[12] = '{32'h003110B3, 32'h102C, 32'h1, 32'h21, 32'h1, 32'h1, 4'h1, 5'd1, 3'd1, 1'b1, 1'b0, 1'b0};
        v[13] = '{32'hFFE0C393, 32'h1030, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFE, 4'h4, 5'd7, 3'd4, 1'b1, 1'b0, 1'b0};

        #1;
        chk_reset("reset");
        step();
        reset = 1'b0;
        #1;
        chk("idle in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            drive(v[i]);
            step();
            chk_vec(v[i], i);
        end

        // stall: downstream holds off while a new instruction waits
        drive(v[0]);
        step();
        out_ready = 1'b0;
        drive(v[6]);
        #1;
        chk("stall in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("stall valid", 32'(out_valid), 32'd1);
            chk("stall a", alu_a, 32'h5);
            chk("stall op", 32'(alu_op), 32'h0);
            chk("stall rd", 32'(out_rd), 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        step();
        chk_vec(v[6], 100);

        in_valid = 1'b0;
        step();
        chk("drain valid", 32'(out_valid), 32'd0);
        chk("drain a hold", alu_a, 32'h9);

        // flush beats in_valid while a result is held
        drive(v[0]);
        step();
        out_ready = 1'b0;
        drive(v[4]);
        flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush valid", 32'(out_valid), 32'd0);
        chk("flush b not loaded", alu_b, 32'h7);

        // async reset in the middle of a stall
        out_ready = 1'b1;
        drive(v[1]);
        step();
        out_ready = 1'b0;
        drive(v[5]);
        step();
        chk("prereset valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("midreset");
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        wb_valid = 1'b1;
        wb_rd = 5'd1;
        wb_data = 32'hAA;
        in_valid = 1'b1;
        instr = 32'h001081B3;
        rs1_data = 32'h5;
        rs2_data = 32'h5;
        step();
        chk("fwd a", alu_a, 32'hAA);
        chk("fwd b", alu_b, 32'hAA);
        wb_rd = 5'd0;
        wb_data = 32'hBB;
        instr = 32'h000001B3;
        step();
        chk("nofwd a", alu_a, 32'h5);
        chk("nofwd b", alu_b, 32'h5);
        wb_valid = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
